// File: rtl/seq_gen_param.sv
// Parametrised linear-recurrence sequence generator: ORDER-deep history, tap-selected sum,
// wrap or saturate on overflow, valid/ready output stream with run-time seed/tap loading.
module seq_gen_param #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      ORDER       = 3,
    parameter logic [ORDER-1:0] TAP_DEFAULT = ORDER'(3'b110)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic [ORDER*WIDTH-1:0] seed_i,
    input  logic [ORDER-1:0]       tap_i,
    input  logic                   sat_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       seq_o,
    output logic                   ovf_o,
    output logic [31:0]            cnt_o
);

    // Sum of up to ORDER terms needs clog2(ORDER) guard bits to expose overflow.
    localparam int unsigned SUM_W = WIDTH + $clog2(ORDER);
    localparam int unsigned IDX_W = $clog2(ORDER);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state_q;
    logic             valid_q;
    logic             sat_q;
    logic             ovf_q;
    logic [ORDER-1:0] tap_q;
    logic [31:0]      cnt_q;
    logic [WIDTH-1:0] h_q    [ORDER];
    logic [WIDTH-1:0] seed_c [ORDER];
    logic [SUM_W-1:0] sum_c;
    logic             sum_ovf_c;
    logic [WIDTH-1:0] next_c;
    logic             adv_c;

    for (genvar g = 0; g < ORDER; g++) begin : g_seed
        assign seed_c[g] = seed_i[g*WIDTH +: WIDTH];
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < ORDER; k++) begin
            if (tap_q[IDX_W'(k)]) begin
                sum_c = sum_c + SUM_W'(h_q[IDX_W'(k)]);
            end
        end
    end

    assign sum_ovf_c = |sum_c[SUM_W-1:WIDTH];
    assign next_c    = (sum_ovf_c && sat_q) ? '1 : sum_c[WIDTH-1:0];
    // A simultaneous load takes priority, so the handshake then moves no history.
    assign adv_c     = (state_q == ST_RUN) && valid_q && ready_i && !load_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                h_q[IDX_W'(k)] <= (k == ORDER - 1) ? '0 : WIDTH'(1);
            end
            tap_q   <= TAP_DEFAULT;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            state_q <= ST_INIT;
        end else if (load_i) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                h_q[IDX_W'(k)] <= seed_c[IDX_W'(k)];
            end
            tap_q   <= tap_i;
            sat_q   <= sat_i;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_INIT: begin
                    valid_q <= 1'b1;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (adv_c) begin
                        for (int unsigned k = 1; k < ORDER; k++) begin
                            h_q[IDX_W'(k)] <= h_q[IDX_W'(k - 1)];
                        end
                        h_q[0] <= next_c;
                        cnt_q  <= cnt_q + 32'd1;
                        if (sum_ovf_c) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign valid_o = valid_q;
    assign seq_o   = h_q[IDX_W'(ORDER - 1)];
    assign ovf_o   = ovf_q;
    assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_seq_gen_param.sv
// Scoreboard bench for seq_gen_param: a 32-bit and an 8-bit instance share control inputs,
// a per-cycle arithmetic model queues expected outputs, a negedge monitor pops and compares.
module tb_seq_gen_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_i = 1'b0;
    logic        sat_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [2:0]  tap_i = 3'b000;
    logic [95:0] seed32_i = '0;
    logic [23:0] seed8_i = '0;

    logic        valid32, ovf32, valid8, ovf8;
    logic [31:0] seq32, cnt32, cnt8;
    logic [7:0]  seq8;

    always #5 clk = ~clk;

    seq_gen_param u_dut32 (
        .clk(clk), .reset(reset), .load_i(load_i), .seed_i(seed32_i), .tap_i(tap_i),
        .sat_i(sat_i), .ready_i(ready_i), .valid_o(valid32), .seq_o(seq32),
        .ovf_o(ovf32), .cnt_o(cnt32)
    );

    seq_gen_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .load_i(load_i), .seed_i(seed8_i), .tap_i(tap_i),
        .sat_i(sat_i), .ready_i(ready_i), .valid_o(valid8), .seq_o(seq8),
        .ovf_o(ovf8), .cnt_o(cnt8)
    );

    typedef struct {
        bit              v;
        longint unsigned seq;
        longint unsigned cnt;
        bit              ovf;
    } rec_t;

    rec_t            q0[$];
    rec_t            q1[$];
    longint unsigned acc0[$];
    longint unsigned acc1[$];

    int unsigned     n_tests = 0;
    int unsigned     n_fail = 0;
    bit              mon_en = 1'b0;

    // Reference state: history as plain integers, index 0 newest.
    longint unsigned mh[2][3];
    bit [2:0]        mtap;
    bit              msat;
    bit              movf[2];
    longint unsigned mcnt;
    bit              mrun;
    longint unsigned sd32[3];
    longint unsigned sd8[3];
    int unsigned     wd[2] = '{32, 8};

    task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mh[d][0] = 1;
            mh[d][1] = 1;
            mh[d][2] = 0;
            movf[d]  = 1'b0;
        end
        mtap = 3'b110;
        msat = 1'b0;
        mcnt = 0;
        mrun = 1'b0;
    endtask

    task automatic model_load(input bit [2:0] tp, input bit st);
        for (int k = 0; k < 3; k++) begin
            mh[0][k] = sd32[k];
            mh[1][k] = sd8[k];
        end
        movf[0] = 1'b0;
        movf[1] = 1'b0;
        mtap = tp;
        msat = st;
        mcnt = 0;
        mrun = 1'b1;
    endtask

    task automatic model_advance();
        for (int d = 0; d < 2; d++) begin
            longint unsigned sum = 0;
            longint unsigned lim = 64'd1 << wd[d];
            longint unsigned nx;
            for (int k = 0; k < 3; k++) begin
                if (mtap[k]) sum += mh[d][k];
            end
            if (sum >= lim) begin
                movf[d] = 1'b1;
                nx = msat ? lim - 1 : sum % lim;
            end else begin
                nx = sum;
            end
            mh[d][2] = mh[d][1];
            mh[d][1] = mh[d][0];
            mh[d][0] = nx;
        end
        mcnt = (mcnt + 1) % (64'd1 << 32);
    endtask

    // One clock cycle: drive inputs after the edge, queue what the DUTs must show, step the model.
    task automatic step(input bit rst, input bit ld, input bit rdy, input bit [2:0] tp, input bit st);
        rec_t r;
        @(posedge clk);
        #1;
        reset    = rst;
        load_i   = ld;
        ready_i  = rdy;
        tap_i    = tp;
        sat_i    = st;
        seed32_i = {sd32[2][31:0], sd32[1][31:0], sd32[0][31:0]};
        seed8_i  = {sd8[2][7:0], sd8[1][7:0], sd8[0][7:0]};
        if (rst || ld) begin
            acc0.delete();
            acc1.delete();
        end
        if (rst) model_reset();
        for (int d = 0; d < 2; d++) begin
            r.v   = mrun;
            r.seq = mh[d][2];
            r.cnt = mcnt;
            r.ovf = movf[d];
            if (d == 0) q0.push_back(r);
            else        q1.push_back(r);
        end
        if (!rst) begin
            if (ld)            model_load(tp, st);
            else if (!mrun)    mrun = 1'b1;
            else if (rdy)      model_advance();
        end
        mon_en = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic mon_one(input int d, input bit v, input longint unsigned s,
                           input longint unsigned c, input bit o);
        rec_t  e;
        string tag = (d == 0) ? "w32" : "w8";
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.queue: got empty scoreboard, required an entry", tag);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk({tag, ".valid"}, 64'(v), 64'(e.v));
        chk({tag, ".seq"}, s, e.seq);
        chk({tag, ".cnt"}, c, e.cnt);
        chk({tag, ".ovf"}, 64'(o), 64'(e.ovf));
        if (v && ready_i && !load_i && !reset) begin
            if (d == 0) acc0.push_back(s);
            else        acc1.push_back(s);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(0, valid32, 64'(seq32), 64'(cnt32), ovf32);
            mon_one(1, valid8, 64'(seq8), 64'(cnt8), ovf8);
        end
    end

    function automatic longint unsigned acc_at(input int d, input int i);
        if (d == 0) return (i < acc0.size()) ? acc0[i] : 64'hFFFF_FFFF_FFFF_FFFF;
        return (i < acc1.size()) ? acc1[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    longint unsigned pad[12] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 7, 9, 12};
    longint unsigned fib[16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
    longint unsigned wrp[4]  = '{144, 233, 121, 98};
    longint unsigned sat[4]  = '{144, 233, 255, 255};

    initial begin
        for (int k = 0; k < 3; k++) begin
            sd32[k] = 0;
            sd8[k]  = 0;
        end
        model_reset();

        // Default Padovan sequence from reset.
        repeat (3) step(1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        repeat (14) step(1'b0, 1'b0, 1'b1, 3'b101, 1'b1);
        settle();
        for (int i = 0; i < 12; i++) chk($sformatf("padovan[%0d]", i), acc_at(0, i), pad[i]);

        // Fibonacci load coinciding with a transfer, with a backpressure gap mid-run.
        sd32 = '{1, 1, 0};
        sd8  = '{1, 1, 0};
        step(1'b0, 1'b1, 1'b1, 3'b011, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
        repeat (14) step(1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
        settle();
        for (int i = 0; i < 16; i++) chk($sformatf("fib32[%0d]", i), acc_at(0, i), fib[i]);
        for (int i = 0; i < 4; i++) chk($sformatf("wrap8[%0d]", i + 12), acc_at(1, i + 12), wrp[i]);

        // Saturating run, then a reload without transfer to clear the sticky flag.
        step(1'b0, 1'b1, 1'b1, 3'b011, 1'b1);
        repeat (16) step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
        settle();
        for (int i = 0; i < 4; i++) chk($sformatf("sat8[%0d]", i + 12), acc_at(1, i + 12), sat[i]);
        chk("sat32[14]", acc_at(0, 14), 377);
        step(1'b0, 1'b1, 1'b0, 3'b011, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);

        // Reset mid-run restarts the default sequence.
        repeat (2) step(1'b1, 1'b0, 1'b1, 3'b111, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b1, 3'b111, 1'b1);
        settle();
        for (int i = 0; i < 3; i++) chk($sformatf("restart[%0d]", i), acc_at(0, i), pad[i]);

        // Randomised traffic: backpressure, loads with random seeds/taps/modes, rare resets.
        repeat (400) begin
            int unsigned r = $urandom_range(0, 99);
            for (int k = 0; k < 3; k++) begin
                sd32[k] = 64'($urandom);
                sd8[k]  = 64'($urandom_range(0, 255));
            end
            step(r < 2, (r >= 2) && (r < 8), $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
        settle();
        chk("scoreboard_drain", 64'(q0.size() + q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_gen_param.md
Name: seq_gen_param

Overview:
Parametrised linear-recurrence sequence generator, the successor to the fixed three-term generator. It keeps an ORDER-deep history and produces each new term as the sum of the history terms selected by a tap mask. Seeds and taps are loadable at run time, overflow can wrap or saturate, and output is a valid/ready stream. It feeds test-pattern and stimulus paths that need deterministic integer sequences (Padovan, Fibonacci, tribonacci, ...).

Parameters:
WIDTH, 32, bit width of each term and of seq_o
ORDER, 3, history depth, i.e. the maximum recurrence order (legal range 2..8)
TAP_DEFAULT, 3'b110, tap mask loaded at reset (ORDER bits; the default gives the Padovan recurrence)

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
load_i  input  1  on this cycle's edge, load seeds and taps and restart
seed_i  input  ORDER*WIDTH  seed image; slice [k*WIDTH +: WIDTH] loads h[k]
tap_i  input  ORDER  tap mask; bit k set means h[k] is included in the sum
sat_i  input  1  1 = saturate on overflow, 0 = wrap modulo 2^WIDTH; sampled on load_i
ready_i  input  1  consumer accepts seq_o this cycle
valid_o  output  1  seq_o holds a valid term
seq_o  output  WIDTH  current term, equal to h[ORDER-1] (the oldest history entry)
ovf_o  output  1  sticky flag: some generated term overflowed WIDTH
cnt_o  output  32  number of accepted transfers since reset or the last load; wraps

Behaviour:
- History: h[0] is the newest entry, h[ORDER-1] the oldest. seq_o = h[ORDER-1] combinationally from registers.
- Reset (asynchronous assert) sets:
  - h[ORDER-1]=0, all other h[k]=1
  - tap register = TAP_DEFAULT, sat register = 0
  - ovf_o=0, cnt_o=0, valid_o=0, state=INIT
- FSM, two states:
  - INIT: valid_o=0. Moves to RUN on the first edge after reset deasserts. The first valid term (h[ORDER-1]) appears on the second cycle after deassert.
  - RUN: valid_o=1.
- Advance occurs when state=RUN && valid_o && ready_i && !load_i:
  - h[k] <= h[k-1] for k>=1; h[0] <= next; cnt_o increments.
  - ready_i low: all state holds and seq_o is stable (standard valid/ready; valid_o never drops while waiting).
- next: sum of the tapped h[k], computed at WIDTH+clog2(ORDER) bits.
  - If the upper bits are nonzero, the sum overflows.
  - Wrap mode: next = low WIDTH bits.
  - Sat mode: next = all-ones.
  - Either mode: ovf_o sets on the advance edge that writes the overflowing sum into h[0]. It is sticky until reset or load.
  - Tap mask all zeros: next = 0 (legal).
- load_i, sampled in any state:
  - h[k] <= seed slice k; tap register <= tap_i; sat register <= sat_i.
  - ovf_o <= 0, cnt_o <= 0, state <= RUN.
  - The seed h[ORDER-1] is visible with valid_o=1 on the next cycle.
  - load_i wins over a simultaneous advance: that cycle's transfer is accepted by the consumer but does not shift history or count.
- Reset mid-run: immediate return to reset values regardless of pending handshake or load.
- tap_i, seed_i and sat_i are ignored when load_i=0.

Test Plan:
1. Reset with defaults (WIDTH=32, ORDER=3), ready_i=1 -> valid_o=0 for the first cycle after deassert, then seq_o = 0,1,1,1,2,2,3,4,5,7,9,12 on consecutive cycles; cnt_o counts 1..12.
2. Load with seeds h2=0, h1=1, h0=1, taps 3'b011, sat=0 -> seq_o = 0,1,1,2,3,5,8,13,21; ovf_o=0.
3. WIDTH=8, Fibonacci load, wrap -> ...,144,233 then 121 (377 mod 256) and 98 (233+121=354 mod 256). ovf_o goes high on the edge writing 377 into h[0], two transfers before 121 reaches seq_o, and stays high.
4. Same as 3 with sat=1 -> ...,144,233,255,255,...; ovf_o=1; a subsequent load clears ovf_o and cnt_o.
5. Backpressure: ready_i toggles 1,0,0,1 mid-sequence -> seq_o and cnt_o hold during the 0 cycles and valid_o stays 1; no term is skipped or duplicated.
6. load_i together with a valid&&ready transfer, then reset asserted mid-run -> history takes the seeds (no shift) and cnt_o=0; during reset valid_o=0 and seq_o=0, and after deassert the default sequence restarts at 0.
